cordic_phase_feeder: RTL and testbench

- Upstream feeder for the pipelined CORDIC rotator; one output sample per clock while running.
- Phase accumulator (NCO) advances a 32-bit angle by a programmable frequency word each cycle.
- Applies quadrant pre-rotation so the residual angle stays within ±90°, and drives angle/x_start/y_start into the CORDIC.
- Tracks CORDIC pipeline latency and flags when x_out/y_out carry valid samples.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_quadrant_prerot.sv | 34 +++
 rtl/cordic_phase_feeder.sv | 145 ++++++++++++++
 tb/tb_cordic_phase_feeder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC phase feeder and its helpers.
package cordic_pkg;

  localparam int          ANGLE_WIDTH  = 32;
  localparam int          XY_WIDTH     = 16;
  localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
  localparam logic [31:0] HALF_TURN    = 32'h8000_0000;
  // 32000 * 0.607, so the CORDIC gain lands the output near full scale
  localparam int          GAIN_INIT    = 19424;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/cordic_quadrant_prerot.sv
// Quadrant pre-rotation: folds an angle into [-90deg, +90deg) and flips the start vector to match.
module cordic_quadrant_prerot #(
  parameter int ANGLE_WIDTH = 32,
  parameter int XY_WIDTH    = 16
) (
  input  logic        [ANGLE_WIDTH-1:0] p,
  input  logic        [XY_WIDTH-1:0]    amp,
  output logic        [ANGLE_WIDTH-1:0] angle,
  output logic signed [XY_WIDTH-1:0]    x_start,
  output logic signed [XY_WIDTH-1:0]    y_start
);

  localparam logic [ANGLE_WIDTH-1:0] HALF = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

  // Magnitudes above the signed maximum are clamped so negation can never overflow.
  function automatic logic signed [XY_WIDTH-1:0] sat_mag(input logic [XY_WIDTH-1:0] a);
    if (a[XY_WIDTH-1]) return {1'b0, {(XY_WIDTH-1){1'b1}}};
    return $signed(a);
  endfunction

  logic signed [XY_WIDTH-1:0] mag;
  assign mag = sat_mag(amp);

  always_comb begin
    angle   = p;
    x_start = mag;
    y_start = '0;
    if (p[ANGLE_WIDTH-1] != p[ANGLE_WIDTH-2]) begin
      angle   = p ^ HALF;
      x_start = -mag;
    end
  end

endmodule

// File: rtl/cordic_phase_feeder.sv
// NCO-driven feeder for the pipelined CORDIC rotator with latency-matched output valid.
// Optional build macro CORDIC_PHASE_DITHER_EN adds LFSR dither to the rotated phase.
module cordic_phase_feeder #(
  parameter int ANGLE_WIDTH    = 32,
  parameter int XY_WIDTH       = 16,
  parameter int CORDIC_LATENCY = 16,
  parameter int GAIN_INIT      = 19424
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic        [ANGLE_WIDTH-1:0] cfg_freq_word,
  input  logic        [ANGLE_WIDTH-1:0] cfg_phase_offset,
  input  logic        [XY_WIDTH-1:0]    cfg_amplitude,
  input  logic                          start,
  input  logic                          stop,
  output logic                          busy,
  output logic        [ANGLE_WIDTH-1:0] angle,
  output logic signed [XY_WIDTH-1:0]    x_start,
  output logic signed [XY_WIDTH-1:0]    y_start,
  output logic                          in_valid,
  output logic                          out_valid,
  output logic        [15:0]            sample_count
);

  import cordic_pkg::*;

  localparam int DCW = (CORDIC_LATENCY > 1) ? $clog2(CORDIC_LATENCY) : 1;

  feeder_state_t state_q, state_d;

  logic        [ANGLE_WIDTH-1:0]    freq_q, offset_q, phase_p0, rot_phase;
  logic        [XY_WIDTH-1:0]       amp_q;
  logic        [ANGLE_WIDTH-1:0]    angle_p0;
  logic signed [XY_WIDTH-1:0]       x_p0, y_p0;
  logic        [CORDIC_LATENCY-1:0] vld_pipe;
  logic        [DCW-1:0]            drain_cnt;
  logic                             cfg_fire, start_fire, emit;

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign start_fire = (state_q == IDLE) & start;
  assign emit       = (state_q == RUN) & ~stop;
  assign out_valid  = vld_pipe[CORDIC_LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN:   if (drain_cnt == DCW'(CORDIC_LATENCY - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freq_q   <= '0;
      offset_q <= '0;
      amp_q    <= XY_WIDTH'(GAIN_INIT);
    end else if (cfg_fire) begin
      freq_q   <= cfg_freq_word;
      offset_q <= cfg_phase_offset;
      amp_q    <= cfg_amplitude;
    end
  end

  // Stage p0: phase accumulator; a same-cycle cfg offset wins over the stored one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           phase_p0 <= '0;
    else if (start_fire) phase_p0 <= cfg_fire ? cfg_phase_offset : offset_q;
    else if (emit)       phase_p0 <= phase_p0 + freq_q;
  end

`ifdef CORDIC_PHASE_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     lfsr_q <= 16'hACE1;
    else if (emit) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign rot_phase = phase_p0 + ANGLE_WIDTH'(lfsr_q);
`else
  assign rot_phase = phase_p0;
`endif

  cordic_quadrant_prerot #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .XY_WIDTH    (XY_WIDTH)
  ) u_prerot (
    .p       (rot_phase),
    .amp     (amp_q),
    .angle   (angle_p0),
    .x_start (x_p0),
    .y_start (y_p0)
  );

  // Stage p1: registered CORDIC inputs; held outside RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      angle    <= '0;
      x_start  <= '0;
      y_start  <= '0;
      in_valid <= 1'b0;
    end else begin
      in_valid <= emit;
      if (emit) begin
        angle   <= angle_p0;
        x_start <= x_p0;
        y_start <= y_p0;
      end
    end
  end

  // Valid shadow of the CORDIC pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < CORDIC_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  drain_cnt <= '0;
    else if (state_q != DRAIN)  drain_cnt <= '0;
    else                        drain_cnt <= drain_cnt + DCW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           sample_count <= '0;
    else if (start_fire) sample_count <= '0;
    else if (out_valid)  sample_count <= sample_count + 16'd1;
  end

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed bench for cordic_phase_feeder: vector table for pre-rotation plus hand sequences for timing corners.
module tb_cordic_phase_feeder;
  import cordic_pkg::*;

  localparam int L = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic        [31:0] cfg_freq_word;
  logic        [31:0] cfg_phase_offset;
  logic        [15:0] cfg_amplitude;
  logic               start;
  logic               stop;
  logic               busy;
  logic        [31:0] angle;
  logic signed [15:0] x_start;
  logic signed [15:0] y_start;
  logic               in_valid;
  logic               out_valid;
  logic        [15:0] sample_count;

  int total = 0;
  int bad   = 0;

  cordic_phase_feeder #(
    .ANGLE_WIDTH    (32),
    .XY_WIDTH       (16),
    .CORDIC_LATENCY (L),
    .GAIN_INIT      (19424)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_freq_word    (cfg_freq_word),
    .cfg_phase_offset (cfg_phase_offset),
    .cfg_amplitude    (cfg_amplitude),
    .start            (start),
    .stop             (stop),
    .busy             (busy),
    .angle            (angle),
    .x_start          (x_start),
    .y_start          (y_start),
    .in_valid         (in_valid),
    .out_valid        (out_valid),
    .sample_count     (sample_count)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        [31:0] freq;
    logic        [31:0] offset;
    logic        [15:0] amp;
    logic        [31:0] a0;
    logic signed [15:0] x0;
    logic        [31:0] a1;
    logic signed [15:0] x1;
  } vec_t;

  vec_t vecs[5];

  logic        [31:0] seq_angle[8];
  logic signed [15:0] seq_x[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [31:0] f, input logic [31:0] o, input logic [15:0] a);
    cfg_valid        = 1'b1;
    cfg_freq_word    = f;
    cfg_phase_offset = o;
    cfg_amplitude    = a;
    tick;
    cfg_valid        = 1'b0;
  endtask

  task automatic wait_idle(output int m);
    m = 0;
    while (busy && m < 200) begin
      tick;
      m++;
    end
  endtask

  task automatic stop_drain(input string nm, input int exp_cnt);
    int m;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk({nm, "_inv_after_stop"}, 32'(in_valid), 32'd0);
    wait_idle(m);
    chk({nm, "_drain_cycles"}, m, L);
    chk({nm, "_count"}, 32'(sample_count), exp_cnt);
    chk({nm, "_outv_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int m;
    int k;

    vecs[0] = '{32'h0000_0001, 32'h3FFF_FFFF, 16'd1234, 32'h3FFF_FFFF,  16'sd1234, 32'hC000_0000, -16'sd1234};
    vecs[1] = '{32'h0000_0001, 32'h7FFF_FFFF, 16'd1234, 32'hFFFF_FFFF, -16'sd1234, 32'h0000_0000, -16'sd1234};
    vecs[2] = '{32'h0000_0001, 32'hBFFF_FFFF, 16'd1234, 32'h3FFF_FFFF, -16'sd1234, 32'hC000_0000,  16'sd1234};
    vecs[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 16'd1234, 32'hFFFF_FFFF,  16'sd1234, 32'h0000_0000,  16'sd1234};
    vecs[4] = '{32'h1000_0000, 32'h9000_0000, 16'd32767, 32'h1000_0000, -16'sd32767, 32'h2000_0000, -16'sd32767};

    seq_angle = '{32'h0000_0000, 32'h2000_0000, 32'hC000_0000, 32'hE000_0000,
                  32'h0000_0000, 32'h2000_0000, 32'hC000_0000, 32'hE000_0000};
    seq_x     = '{16'sd19424, 16'sd19424, -16'sd19424, -16'sd19424,
                  -16'sd19424, -16'sd19424, 16'sd19424, 16'sd19424};

    reset            = 1'b1;
    cfg_valid        = 1'b0;
    cfg_freq_word    = '0;
    cfg_phase_offset = '0;
    cfg_amplitude    = '0;
    start            = 1'b0;
    stop             = 1'b0;

    // Reset state
    #12;
    chk("rst_angle", angle, 32'd0);
    chk("rst_x", 32'(x_start), 32'd0);
    chk("rst_y", 32'(y_start), 32'd0);
    chk("rst_inv", 32'(in_valid), 32'd0);
    chk("rst_outv", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    tick;
    chk("idle_busy", 32'(busy), 32'd0);

    // Default configuration: phase 0, freq 0, amplitude GAIN_INIT
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("def_first_lat_inv", 32'(in_valid), 32'd0);
    chk("def_busy", 32'(busy), 32'd1);
    chk("def_cfg_ready", 32'(cfg_ready), 32'd0);
    tick;
    chk("def_inv", 32'(in_valid), 32'd1);
    chk("def_angle", angle, 32'd0);
    chk("def_amp", 32'(x_start), 32'(GAIN_INIT));
    stop_drain("def", 1);

    // Pre-rotation table across the quadrant boundaries
    for (int i = 0; i < 5; i++) begin
      do_cfg(vecs[i].freq, vecs[i].offset, vecs[i].amp);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      chk($sformatf("vec%0d_a0", i), angle, vecs[i].a0);
      chk($sformatf("vec%0d_x0", i), 32'(x_start), 32'(vecs[i].x0));
      chk($sformatf("vec%0d_y0", i), 32'(y_start), 32'd0);
      tick;
      chk($sformatf("vec%0d_a1", i), angle, vecs[i].a1);
      chk($sformatf("vec%0d_x1", i), 32'(x_start), 32'(vecs[i].x1));
      stop_drain($sformatf("vec%0d", i), 2);
    end

    // 45 degree stepping, with a rejected cfg offer mid-run and a start ignored in DRAIN
    do_cfg(32'h2000_0000, 32'h0, 16'd19424);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("step45_angle%0d", i), angle, seq_angle[i]);
      chk($sformatf("step45_x%0d", i), 32'(x_start), 32'(seq_x[i]));
      chk($sformatf("step45_y%0d", i), 32'(y_start), 32'd0);
      if (i == 3) begin
        cfg_valid        = 1'b1;
        cfg_freq_word    = 32'h0000_0100;
        cfg_phase_offset = 32'h1234_5678;
        cfg_amplitude    = 16'd5;
        chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
      end
      if (i == 4) cfg_valid = 1'b0;
      tick;
    end
    stop = 1'b1;
    tick;
    stop  = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("drain_start_inv", 32'(in_valid), 32'd0);
    chk("drain_start_busy", 32'(busy), 32'd1);
    wait_idle(m);
    chk("drain_start_cycles", m + 1, L);
    chk("step45_count", 32'(sample_count), 32'd9);

    // Latency run: config offered during RUN must not have taken effect
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("lat_angle0", angle, 32'h0);
    chk("lat_x0", 32'(x_start), 32'sd19424);
    chk("lat_outv0", 32'(out_valid), 32'd0);
    k = 0;
    while (!out_valid && k < 100) begin
      tick;
      k++;
    end
    chk("lat_outv_delay", k, L);
    stop_drain("lat", L + 1);

    // Phase wrap with cfg and start in the same cycle, then start+stop together
    cfg_valid        = 1'b1;
    cfg_freq_word    = 32'h0000_0020;
    cfg_phase_offset = 32'hFFFF_FFF0;
    cfg_amplitude    = 16'd1000;
    start            = 1'b1;
    tick;
    cfg_valid = 1'b0;
    start     = 1'b0;
    tick;
    chk("wrap_angle0", angle, 32'hFFFF_FFF0);
    chk("wrap_x0", 32'(x_start), 32'sd1000);
    tick;
    chk("wrap_angle1", angle, 32'h0000_0010);
    chk("wrap_x1", 32'(x_start), 32'sd1000);
    start = 1'b1;
    stop  = 1'b1;
    tick;
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd1);
    chk("startstop_inv", 32'(in_valid), 32'd0);
    wait_idle(m);
    chk("startstop_drain", m, L);
    chk("startstop_count", 32'(sample_count), 32'd2);

    // Sample counter wrap after 65537 samples
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (65537) tick;
    stop_drain("cnt_wrap", 1);

    // Asynchronous reset in the middle of RUN
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    chk("mid_angle", angle, 32'h0000_0250);
    chk("mid_x", 32'(x_start), 32'sd1000);
    chk("mid_outv", 32'(out_valid), 32'd1);
    chk("mid_count", 32'(sample_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_angle", angle, 32'd0);
    chk("arst_x", 32'(x_start), 32'd0);
    chk("arst_inv", 32'(in_valid), 32'd0);
    chk("arst_outv", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(sample_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
